// File: rtl/som_pkg.sv
// Shared definitions for the sequential minterm encoder.
package som_pkg;

  localparam int unsigned N_MT  = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_t;

  // Number of set minterms in a 16-bit vector.
  function automatic logic [4:0] popcount16(input logic [0:15] v);
    logic [4:0] c;
    c = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/enc_4x2_prio.sv
// 4-input priority encoder, lowest index wins; any flags a set input.
module enc_4x2_prio (
  input  logic [3:0] d,
  output logic [1:0] code,
  output logic       any
);

  // Later assignments override earlier ones, so the lowest set bit decides.
  always_comb begin
    code = '0;
    any  = |d;
    if (d[3]) code = 2'd3;
    if (d[2]) code = 2'd2;
    if (d[1]) code = 2'd1;
    if (d[0]) code = 2'd0;
  end

endmodule

// File: rtl/som_enc_16x4_seq.sv
// Sequential minterm encoder: emits the index of every set minterm of a
// 16-bit vector in ascending order, one per idx_valid/idx_ready handshake.
// Optional popcount output enabled by macro SOM_ENC_COUNT_EN.
module som_enc_16x4_seq #(
  parameter int unsigned N_MT  = som_pkg::N_MT,
  parameter int unsigned IDX_W = som_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [0:15]      m_in,
  output logic             busy,
  output logic             idx_valid,
  output logic [IDX_W-1:0] idx,
  input  logic             idx_ready,
  output logic             done,
  output logic             empty
`ifdef SOM_ENC_COUNT_EN
  , output logic [4:0]     cnt
`endif
);

  import som_pkg::*;

  if (N_MT != 16 || IDX_W != 4) begin : g_bad_cfg
    $error("som_enc_16x4_seq supports only N_MT=16, IDX_W=4");
  end

  state_t      state_q, state_d;
  logic [0:15] pending_q, pending_d;
  logic        empty_q, empty_d;

  logic [1:0]  gcode [4];
  logic [3:0]  gany;
  logic [1:0]  top_code;
  logic        top_any;
  logic [3:0]  idx_c;

  // Reverse decoder tree: four group encoders, then one over the group flags.
  for (genvar g = 0; g < 4; g++) begin : g_grp
    enc_4x2_prio u_grp (
      .d    ({pending_q[4*g+3], pending_q[4*g+2], pending_q[4*g+1], pending_q[4*g]}),
      .code (gcode[g]),
      .any  (gany[g])
    );
  end

  enc_4x2_prio u_top (
    .d    (gany),
    .code (top_code),
    .any  (top_any)
  );

  assign idx_c = {top_code, gcode[top_code]};

  // State, pending vector and empty flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      empty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      empty_q   <= empty_d;
    end
  end

  // Next-state, pending-bit retirement and handshake outputs.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    empty_d   = empty_q;
    busy      = 1'b0;
    idx_valid = 1'b0;
    idx       = '0;
    done      = 1'b0;
    empty     = empty_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          pending_d = m_in;
          if (m_in != '0) begin
            state_d = SCAN;
          end else begin
            state_d = DONE;
            empty_d = 1'b1;
          end
        end
      end
      SCAN: begin
        busy      = 1'b1;
        idx_valid = top_any;
        idx       = idx_c;
        if (idx_ready && top_any) begin
          pending_d[idx_c] = 1'b0;
          if (pending_d == '0) state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        empty_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef SOM_ENC_COUNT_EN
  // Population count of the accepted vector, held until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state_q == IDLE && start) begin
      cnt <= popcount16(m_in);
    end
  end
`endif

endmodule

// File: tb/tb_som_enc_16x4_seq.sv
// Directed self-checking bench for som_enc_16x4_seq.
module tb_som_enc_16x4_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [0:15] m_in;
  logic        busy;
  logic        idx_valid;
  logic [3:0]  idx;
  logic        idx_ready;
  logic        done;
  logic        empty;
`ifdef SOM_ENC_COUNT_EN
  logic [4:0]  cnt;
`endif

  int passed;
  int total;
  int exp_q[$];

  som_enc_16x4_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .m_in      (m_in),
    .busy      (busy),
    .idx_valid (idx_valid),
    .idx       (idx),
    .idx_ready (idx_ready),
    .done      (done),
    .empty     (empty)
`ifdef SOM_ENC_COUNT_EN
    , .cnt     (cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load v, then walk the expected index list in exp_q.
  // stall_at: index at which idx_ready drops for 3 cycles (-1 = never).
  // busy_start: keep start high with a different vector while busy.
  task automatic run_seq(input string tag, input logic [0:15] v, input int stall_at,
                         input bit busy_start, input int exp_cnt);
    bit stalled;
    stalled   = 0;
    start     = 1'b1;
    m_in      = v;
    idx_ready = 1'b1;
    tick();
    if (busy_start) m_in = ~v;
    else start = 1'b0;
`ifdef SOM_ENC_COUNT_EN
    check({tag, " cnt"}, 32'(cnt), 32'(exp_cnt));
`else
    if (exp_cnt < 0) $display("unexpected count argument");
`endif
    foreach (exp_q[i]) begin
      if (exp_q[i] == stall_at && !stalled) begin
        stalled   = 1;
        idx_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          check({tag, " stall valid"}, 32'(idx_valid), 1);
          check({tag, " stall idx"}, 32'(idx), 32'(exp_q[i]));
          tick();
        end
        idx_ready = 1'b1;
      end
      check({tag, " valid"}, 32'(idx_valid), 1);
      check({tag, " idx"}, 32'(idx), 32'(exp_q[i]));
      check({tag, " no done"}, 32'(done), 0);
      tick();
    end
    start = 1'b0;
    check({tag, " done"}, 32'(done), 1);
    check({tag, " done empty"}, 32'(empty), 0);
    check({tag, " done valid"}, 32'(idx_valid), 0);
    tick();
    check({tag, " idle busy"}, 32'(busy), 0);
    check({tag, " idle done"}, 32'(done), 0);
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    rst       = 1'b1;
    start     = 1'b0;
    m_in      = '0;
    idx_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset busy", 32'(busy), 0);
    check("reset valid", 32'(idx_valid), 0);
    check("reset done", 32'(done), 0);
    check("reset empty", 32'(empty), 0);
    check("reset idx", 32'(idx), 0);
`ifdef SOM_ENC_COUNT_EN
    check("reset cnt", 32'(cnt), 0);
`endif
    tick();
    check("idle busy", 32'(busy), 0);

    // Minterms {4,5,11,12,13,14,15}: 16'b0000_1100_0001_1111 in m[0:15] order.
    exp_q = '{4, 5, 11, 12, 13, 14, 15};
    run_seq("som", 16'b0000_1100_0001_1111, -1, 0, 7);
    run_seq("bp", 16'b0000_1100_0001_1111, 11, 0, 7);
    run_seq("busystart", 16'b0000_1100_0001_1111, -1, 1, 7);

    // All ones: indices 0..15.
    exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    run_seq("ones", 16'hFFFF, -1, 0, 16);

    // Only minterm 15.
    exp_q = '{15};
    run_seq("bit15", 16'b0000_0000_0000_0001, -1, 0, 1);

    // Only minterm 0 plus minterm 9.
    exp_q = '{0, 9};
    run_seq("b0b9", 16'b1000_0000_0100_0000, -1, 0, 2);

    // Empty vector.
    start = 1'b1;
    m_in  = '0;
    tick();
    start = 1'b0;
    check("empty done", 32'(done), 1);
    check("empty flag", 32'(empty), 1);
    check("empty valid", 32'(idx_valid), 0);
    check("empty busy", 32'(busy), 1);
`ifdef SOM_ENC_COUNT_EN
    check("empty cnt", 32'(cnt), 0);
`endif
    tick();
    check("empty after done", 32'(done), 0);
    check("empty after flag", 32'(empty), 0);
    check("empty after busy", 32'(busy), 0);

    // Reset in SCAN aborts with no done pulse.
    start     = 1'b1;
    m_in      = 16'b0000_1100_0001_1111;
    idx_ready = 1'b0;
    tick();
    start = 1'b0;
    check("abort first idx", 32'(idx), 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", 32'(busy), 0);
    check("abort valid", 32'(idx_valid), 0);
    check("abort done", 32'(done), 0);
    check("abort idx", 32'(idx), 0);
    tick();
    check("abort later done", 32'(done), 0);
    check("abort later busy", 32'(busy), 0);

    // start together with rst: reset wins.
    rst   = 1'b1;
    start = 1'b1;
    m_in  = 16'hFFFF;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("rst+start busy", 32'(busy), 0);
    check("rst+start valid", 32'(idx_valid), 0);
    tick();
    check("rst+start later busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
